// File: rtl/esti_pkg.sv
// Shared types and defaults for the estimator sampling front-end.
package esti_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        REQ,
        PUSH,
        DONE
    } sc_state_t;

    typedef logic [1:0]        axis_t;
    typedef logic signed [15:0] acc_t;

    localparam axis_t AXIS_X = 2'd0;
    localparam axis_t AXIS_Y = 2'd1;
    localparam axis_t AXIS_Z = 2'd2;

    localparam int DEF_CLK_DIV  = 50000;
    localparam int DEF_NUM_AXES = 3;
    localparam int DEF_TIMEOUT  = 255;

    function automatic logic is_last_axis(input axis_t axis, input int num_axes);
        return axis == axis_t'(num_axes - 1);
    endfunction

endpackage

// File: rtl/esti_tick_gen.sv
// Sample-period divider: one-cycle tick every CLK_DIV cycles while enabled.
module esti_tick_gen #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt_q;
    logic             wrap;

    assign wrap   = cnt_q == CNT_W'(CLK_DIV - 1);
    assign tick_o = enable_i && wrap;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (!enable_i || wrap) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/esti_sample_ctrl.sv
// Periodic X/Y/Z accelerometer sampler: sensor req/ack in, esti_core valid/ready out,
// with sticky overrun and sensor-timeout flags.
module esti_sample_ctrl
    import esti_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int NUM_AXES = DEF_NUM_AXES,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        clr_err_i,
    output logic        sens_req_o,
    output logic [1:0]  sens_axis_o,
    input  logic        sens_ack_i,
    input  logic [15:0] sens_data_i,
    output logic        core_valid_o,
    input  logic        core_ready_i,
    output logic [1:0]  core_axis_o,
    output logic [15:0] core_data_o,
    output logic        frame_done_o,
    output logic        overrun_o,
    output logic        timeout_err_o
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    sc_state_t       state_q, state_d;
    axis_t           axis_q, axis_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    acc_t            core_data_q, core_data_d;
    axis_t           core_axis_q, core_axis_d;
    logic            overrun_q, overrun_d;
    logic            timeout_q, timeout_d;

    logic tick;
    logic req_expired;
    logic last_axis;

    esti_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .enable_i (enable_i),
        .tick_o   (tick)
    );

    assign req_expired = to_cnt_q == TO_W'(TIMEOUT - 1);
    assign last_axis   = is_last_axis(axis_q, NUM_AXES);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            axis_q      <= AXIS_X;
            to_cnt_q    <= '0;
            core_data_q <= '0;
            core_axis_q <= AXIS_X;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            axis_q      <= axis_d;
            to_cnt_q    <= to_cnt_d;
            core_data_q <= core_data_d;
            core_axis_q <= core_axis_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    // NOTE: each combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (enable_i) state_d = WAIT_TICK;
            WAIT_TICK: begin
                if (!enable_i)  state_d = IDLE;
                else if (tick)  state_d = REQ;
            end
            REQ: begin
                if (sens_ack_i)       state_d = PUSH;
                else if (req_expired) state_d = WAIT_TICK;
            end
            PUSH:      if (core_ready_i) state_d = last_axis ? DONE : REQ;
            DONE:      state_d = enable_i ? WAIT_TICK : IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Sticky flags: a set event in the same cycle as clr_err wins.
    always_comb begin
        axis_d      = axis_q;
        to_cnt_d    = to_cnt_q;
        core_data_d = core_data_q;
        core_axis_d = core_axis_q;
        overrun_d   = overrun_q & ~clr_err_i;
        timeout_d   = timeout_q & ~clr_err_i;

        if (tick && state_q != WAIT_TICK) overrun_d = 1'b1;

        case (state_q)
            WAIT_TICK: begin
                if (tick) begin
                    axis_d   = AXIS_X;
                    to_cnt_d = '0;
                end
            end
            REQ: begin
                if (sens_ack_i) begin
                    core_data_d = acc_t'(sens_data_i);
                    core_axis_d = axis_q;
                end else if (req_expired) begin
                    timeout_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            PUSH: begin
                if (core_ready_i && !last_axis) begin
                    axis_d   = axis_q + axis_t'(1);
                    to_cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        sens_req_o    = state_q == REQ;
        sens_axis_o   = axis_q;
        core_valid_o  = state_q == PUSH;
        core_axis_o   = core_axis_q;
        core_data_o   = core_data_q;
        frame_done_o  = state_q == DONE;
        overrun_o     = overrun_q;
        timeout_err_o = timeout_q;
    end

endmodule

// File: tb/tb_esti_sample_ctrl.sv
// Bench for esti_sample_ctrl: sensor model plus scoreboard monitor on the core handshake.
module tb_esti_sample_ctrl;
    import esti_pkg::*;

    localparam int CLK_DIV  = 16;
    localparam int NUM_AXES = 3;
    localparam int TIMEOUT  = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        clr_err = 1'b0;
    logic        sens_ack = 1'b0;
    logic [15:0] sens_data = '0;
    logic        core_ready = 1'b0;
    logic        sens_req, core_valid, frame_done, overrun, timeout_err;
    logic [1:0]  sens_axis, core_axis;
    logic [15:0] core_data;

    esti_sample_ctrl #(
        .CLK_DIV  (CLK_DIV),
        .NUM_AXES (NUM_AXES),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .enable_i      (enable),
        .clr_err_i     (clr_err),
        .sens_req_o    (sens_req),
        .sens_axis_o   (sens_axis),
        .sens_ack_i    (sens_ack),
        .sens_data_i   (sens_data),
        .core_valid_o  (core_valid),
        .core_ready_i  (core_ready),
        .core_axis_o   (core_axis),
        .core_data_o   (core_data),
        .frame_done_o  (frame_done),
        .overrun_o     (overrun),
        .timeout_err_o (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  axis;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          frame_cnt = 0;
    logic [15:0] data_tbl [4];
    int          ack_dly = 0;
    logic [3:0]  ack_mask = '0;
    int          model_wcnt = 0;
    logic        stall_q = 1'b0;
    logic [17:0] stall_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic push_frame();
        exp_t e;
        for (int a = 0; a < NUM_AXES; a++) begin
            e.axis = 2'(a);
            e.data = data_tbl[a];
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        enable     = 1'b0;
        clr_err    = 1'b0;
        core_ready = 1'b0;
        ack_mask   = '0;
        ack_dly    = 0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_req(input logic [1:0] axis, input int budget, input string name);
        int n = 0;
        while (!(sens_req && sens_axis == axis) && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(sens_req && sens_axis == axis), 32'd1);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (!core_valid && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(core_valid), 32'd1);
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n = 0;
        while (frame_cnt < target && n < budget) begin
            step();
            n++;
        end
        check(name, frame_cnt, target);
    endtask

    // Sensor: acks ack_dly cycles after sens_req is first seen, unless the axis is masked.
    initial begin : sensor_model
        forever begin
            @(posedge clk);
            #1;
            sens_ack = 1'b0;
            if (sens_req && !ack_mask[sens_axis]) begin
                if (model_wcnt == ack_dly) begin
                    sens_ack   = 1'b1;
                    sens_data  = data_tbl[sens_axis];
                    model_wcnt = 0;
                end else begin
                    model_wcnt++;
                end
            end else begin
                model_wcnt = 0;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_q = 1'b0;
            end else begin
                if (frame_done) frame_cnt++;
                if (stall_q) begin
                    check("hold_valid", 32'(core_valid), 32'd1);
                    check("hold_word", 32'({core_axis, core_data}), 32'(stall_word));
                end
                if (core_valid) begin
                    check("no_req_in_push", 32'(sens_req), 32'd0);
                    if (core_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_sample: got axis %0d data 0x%04h, expected none",
                                     core_axis, core_data);
                        end else begin
                            mon_e = exp_q.pop_front();
                            check("sample_axis", 32'(core_axis), 32'(mon_e.axis));
                            check("sample_data", 32'(core_data), 32'(mon_e.data));
                        end
                    end
                end
                stall_q    = core_valid && !core_ready;
                stall_word = {core_axis, core_data};
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        int f0;
        int e0;

        data_tbl = '{16'h0123, 16'hFEDC, 16'h7FFF, 16'h1111};

        // 1: reset values, first-request latency, reset asserted mid-REQ
        step();
        step();
        check("rst_outputs", 32'({sens_req, sens_axis, core_valid, core_axis, frame_done, overrun, timeout_err}), 32'd0);
        check("rst_core_data", 32'(core_data), 32'd0);
        reset    = 1'b0;
        ack_mask = 4'hF;
        enable   = 1'b1;
        n = 0;
        while (!sens_req && n < 40) begin
            step();
            n++;
        end
        check("t1_req_latency", n, 16);
        #3 reset = 1'b1;
        #1;
        check("t1_async_rst_outputs", 32'({sens_req, sens_axis, core_valid, core_axis, frame_done, overrun, timeout_err}), 32'd0);
        step();
        reset = 1'b0;
        n = 0;
        while (!sens_req && n < 40) begin
            step();
            n++;
        end
        check("t1_req_latency_after_rst", n, 16);

        // 2: two back-to-back frames, ack after 2 cycles, ready tied high
        do_reset();
        ack_dly    = 2;
        core_ready = 1'b1;
        push_frame();
        push_frame();
        f0 = frame_cnt;
        enable = 1'b1;
        wait_frames(f0 + 2, 200, "t2_two_frames");
        enable = 1'b0;
        step();
        step();
        check("t2_drained", exp_q.size(), 0);
        check("t2_no_errors", 32'({overrun, timeout_err}), 32'd0);

        // 3: core stalls 5 cycles in PUSH
        do_reset();
        ack_dly    = 0;
        core_ready = 1'b0;
        push_frame();
        f0 = frame_cnt;
        enable = 1'b1;
        wait_valid(40, "t3_first_valid");
        repeat (5) step();
        core_ready = 1'b1;
        wait_frames(f0 + 1, 40, "t3_frame");
        enable = 1'b0;
        step();
        check("t3_drained", exp_q.size(), 0);
        check("t3_no_overrun", 32'(overrun), 32'd0);

        // 4: sensor never acks axis 1 -> timeout, frame abandoned, next frame restarts at X
        do_reset();
        ack_dly    = 0;
        ack_mask   = 4'b0010;
        core_ready = 1'b1;
        data_tbl   = '{16'h0123, 16'hFEDC, 16'h7FFF, 16'h1111};
        exp_q.push_back(exp_t'{2'd0, 16'h0123});
        f0 = frame_cnt;
        enable = 1'b1;
        wait_req(2'd1, 60, "t4_req_axis1");
        n = 0;
        while (sens_req && n < 400) begin
            n++;
            step();
        end
        ack_mask = '0;
        check("t4_req_cycles", n, TIMEOUT);
        check("t4_timeout_set", 32'(timeout_err), 32'd1);
        check("t4_no_frame_done", frame_cnt, f0);
        check("t4_overrun_from_ticks", 32'(overrun), 32'd1);
        push_frame();
        wait_frames(f0 + 1, 60, "t4_next_frame");
        enable = 1'b0;
        step();
        step();
        check("t4_timeout_sticky", 32'(timeout_err), 32'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("t4_clr_err", 32'({overrun, timeout_err}), 32'd0);
        check("t4_drained", exp_q.size(), 0);

        // 5: core stalls across ticks -> overrun; clr on a tick cycle loses to the set
        do_reset();
        data_tbl   = '{16'h8000, 16'h0001, 16'hAAAA, 16'h0000};
        ack_dly    = 0;
        core_ready = 1'b0;
        push_frame();
        f0 = frame_cnt;
        enable = 1'b1;
        e0 = cyc;
        step_to(e0 + 20);
        check("t5_start_tick_no_overrun", 32'(overrun), 32'd0);
        step_to(e0 + 33);
        check("t5_overrun_set", 32'(overrun), 32'd1);
        check("t5_valid_held", 32'(core_valid), 32'd1);
        step_to(e0 + 40);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("t5_clr_alone", 32'(overrun), 32'd0);
        step_to(e0 + 47);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("t5_set_wins_over_clr", 32'(overrun), 32'd1);
        step_to(e0 + 49);
        core_ready = 1'b1;
        wait_frames(f0 + 1, 40, "t5_frame");
        enable = 1'b0;
        step();
        check("t5_drained", exp_q.size(), 0);

        // 6: enable dropped during axis 1 -> frame completes, then no more requests
        do_reset();
        data_tbl   = '{16'h0123, 16'hFEDC, 16'h7FFF, 16'h1111};
        ack_dly    = 2;
        core_ready = 1'b1;
        push_frame();
        f0 = frame_cnt;
        enable = 1'b1;
        wait_req(2'd1, 60, "t6_req_axis1");
        enable = 1'b0;
        wait_frames(f0 + 1, 40, "t6_frame_done");
        n = 0;
        repeat (40) begin
            step();
            if (sens_req) n++;
        end
        check("t6_no_req_after", n, 0);
        check("t6_drained", exp_q.size(), 0);

        // 7: ack arriving on the expiry cycle wins over the timeout
        do_reset();
        ack_dly    = TIMEOUT - 1;
        core_ready = 1'b1;
        push_frame();
        f0 = frame_cnt;
        enable = 1'b1;
        wait_frames(f0 + 1, 1200, "t7_frame");
        enable = 1'b0;
        step();
        check("t7_no_timeout", 32'(timeout_err), 32'd0);
        check("t7_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
